// File: rtl/i2s_dac_tx.sv
// I2S transmitter: serialises buffered stereo PCM frames onto aud_dacdat, MSB first,
// one bclk after each LRC edge, using bclk/lrc from a generator in the same clk domain.
module i2s_dac_tx #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aud_bclk,
  input  logic              aud_lrc,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              aud_dacdat,
  output logic              frame_start,
  output logic              underrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t            state_r;
  logic              bclk_d_r;
  logic              lrc_d_r;
  logic [4:0]        bit_idx_r;
  logic [DATA_W-1:0] buf_left_r;
  logic [DATA_W-1:0] buf_right_r;
  logic [DATA_W-1:0] sh_left_r;
  logic [DATA_W-1:0] sh_right_r;

  logic              fall_s;
  logic              slot_start_s;
  logic              load_s;
  logic              accept_s;
  logic [DATA_W-1:0] cur_word_s;
  logic [4:0]        bit_idx_nxt_s;
  logic              data_bit_s;

  // Bit k (1..DATA_W) of a slot carries word bit DATA_W-k; everything else is padding.
  function automatic logic pick_bit(input logic [DATA_W-1:0] word, input logic [4:0] idx);
    logic [DATA_W-1:0] shifted;
    shifted = {DATA_W{1'b0}};
    if ((idx == 5'd0) || (idx > 5'(DATA_W))) begin
      pick_bit = 1'b0;
    end else begin
      shifted  = word >> (5'(DATA_W) - idx);
      pick_bit = shifted[0];
    end
  endfunction

  // Edge detection, frame load decision and current output bit.
  always_comb begin
    fall_s        = bclk_d_r & ~aud_bclk;
    slot_start_s  = fall_s & (aud_lrc != lrc_d_r);
    load_s        = slot_start_s & ~aud_lrc & ((state_r == ST_IDLE) || (state_r == ST_RIGHT));
    accept_s      = s_valid & s_ready;
    bit_idx_nxt_s = (bit_idx_r == 5'd31) ? 5'd31 : (bit_idx_r + 5'd1);
    case (state_r)
      ST_LEFT:  cur_word_s = sh_left_r;
      ST_RIGHT: cur_word_s = sh_right_r;
      default:  cur_word_s = {DATA_W{1'b0}};
    endcase
    data_bit_s = pick_bit(cur_word_s, bit_idx_r);
  end

  // Slot FSM, bit counter, shift registers and registered serial/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bclk_d_r    <= 1'b0;
      lrc_d_r     <= 1'b0;
      bit_idx_r   <= 5'd0;
      sh_left_r   <= {DATA_W{1'b0}};
      sh_right_r  <= {DATA_W{1'b0}};
      aud_dacdat  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      bclk_d_r    <= aud_bclk;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall_s) begin
        lrc_d_r <= aud_lrc;
        if (slot_start_s) begin
          bit_idx_r  <= 5'd1;
          aud_dacdat <= 1'b0;
          case (state_r)
            ST_IDLE:  if (!aud_lrc) state_r <= ST_LEFT;
            ST_LEFT:  if (aud_lrc)  state_r <= ST_RIGHT;
            ST_RIGHT: if (!aud_lrc) state_r <= ST_LEFT;
            default:  state_r <= ST_IDLE;
          endcase
          // Both channels are captured together so a frame is never torn.
          if (load_s) begin
            frame_start <= 1'b1;
            if (!s_ready) begin
              sh_left_r  <= buf_left_r;
              sh_right_r <= buf_right_r;
            end else begin
              underrun   <= 1'b1;
              sh_left_r  <= {DATA_W{1'b0}};
              sh_right_r <= {DATA_W{1'b0}};
            end
          end
        end else begin
          bit_idx_r  <= bit_idx_nxt_s;
          aud_dacdat <= data_bit_s;
        end
      end
    end
  end

  // Single-entry frame buffer; s_ready doubles as the buffer-empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready     <= 1'b1;
      buf_left_r  <= {DATA_W{1'b0}};
      buf_right_r <= {DATA_W{1'b0}};
    end else if (load_s && !s_ready) begin
      s_ready <= 1'b1;
    end else if (accept_s) begin
      s_ready     <= 1'b0;
      buf_left_r  <= s_left;
      buf_right_r <= s_right;
    end
  end

endmodule
